// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported 32-bit memory between the instruction-fetch port
//   and the load/store data port. Each requester holds req until it sees a
//   one-cycle valid pulse. Requests are serialized onto a registered memory bus.
//   A bounded wait timer turns a missing acknowledge into an error completion.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   if_req/if_addr        fetch request and address
//   if_rdata/if_valid     fetched word and its completion pulse
//   d_req/d_addr/d_wdata/d_wmask   data request (d_wmask == 0 means read)
//   d_rdata/d_valid       load word and its completion pulse
//   err                   high with a valid pulse when the transaction timed out
//   mem_req/mem_addr/mem_wdata/mem_wmask   registered memory bus
//   mem_ack/mem_rdata     one-cycle acknowledge with read data
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 16  // legal range 2..255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wmask,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
  typedef enum logic {GRANT_I, GRANT_D} grant_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      state, state_nx;
  grant_t      last_grant, last_grant_nx;
  logic [7:0]  wait_cnt, wait_cnt_nx;
  logic        mem_req_nx;
  logic [31:0] mem_addr_nx, mem_wdata_nx;
  logic [3:0]  mem_wmask_nx;
  logic [31:0] if_rdata_nx, d_rdata_nx;
  logic        if_valid_nx, d_valid_nx, err_nx;
  logic        if_elig, d_elig, pick_d;

  // The memory is word addressed; byte offsets are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, if_addr[1:0], d_addr[1:0]};

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= GRANT_I;
      wait_cnt   <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wmask  <= '0;
      if_rdata   <= '0;
      if_valid   <= 1'b0;
      d_rdata    <= '0;
      d_valid    <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nx;
      last_grant <= last_grant_nx;
      wait_cnt   <= wait_cnt_nx;
      mem_req    <= mem_req_nx;
      mem_addr   <= mem_addr_nx;
      mem_wdata  <= mem_wdata_nx;
      mem_wmask  <= mem_wmask_nx;
      if_rdata   <= if_rdata_nx;
      if_valid   <= if_valid_nx;
      d_rdata    <= d_rdata_nx;
      d_valid    <= d_valid_nx;
      err        <= err_nx;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the case statement can leave a value unassigned (no latches).
    state_nx      = state;
    last_grant_nx = last_grant;
    wait_cnt_nx   = wait_cnt;
    mem_req_nx    = mem_req;
    mem_addr_nx   = mem_addr;
    mem_wdata_nx  = mem_wdata;
    mem_wmask_nx  = mem_wmask;
    if_rdata_nx   = if_rdata;
    d_rdata_nx    = d_rdata;
    if_valid_nx   = 1'b0;
    d_valid_nx    = 1'b0;
    err_nx        = 1'b0;

    // A port whose valid is high this cycle is retiring its request; it must
    // not be granted again off the same still-high req.
    if_elig = if_req && !if_valid;
    d_elig  = d_req && !d_valid;
    pick_d  = d_elig && !(if_elig && last_grant == GRANT_D);

    case (state)
      IDLE: begin
        if (if_elig || d_elig) begin
          mem_req_nx  = 1'b1;
          wait_cnt_nx = '0;
          if (pick_d) begin
            state_nx      = BUSY_D;
            last_grant_nx = GRANT_D;
            mem_addr_nx   = {d_addr[31:2], 2'b00};
            mem_wdata_nx  = d_wdata;
            mem_wmask_nx  = d_wmask;
          end else begin
            state_nx      = BUSY_I;
            last_grant_nx = GRANT_I;
            mem_addr_nx   = {if_addr[31:2], 2'b00};
            mem_wdata_nx  = '0;
            mem_wmask_nx  = '0;
          end
        end
      end
      BUSY_I, BUSY_D: begin
        // An ack in the final wait cycle still counts as success.
        if (mem_ack || wait_cnt == LAST_WAIT) begin
          state_nx    = IDLE;
          mem_req_nx  = 1'b0;
          wait_cnt_nx = '0;
          err_nx      = !mem_ack;
          if (state == BUSY_I) begin
            if_valid_nx = 1'b1;
            if_rdata_nx = mem_ack ? mem_rdata : '0;
          end else begin
            d_valid_nx = 1'b1;
            d_rdata_nx = mem_ack ? mem_rdata : '0;
          end
        end else begin
          wait_cnt_nx = wait_cnt + 8'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed scenarios for latency, arbitration order, wait states, timeout,
//   reset abort and retiring requests, followed by a randomized phase checked
//   against a transaction-level reference model of the two requesters and
//   the memory bus.
module tb_mem_port_arbiter;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, mem_ack;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_wmask;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_valid, d_valid, err, mem_req;
  logic [3:0]  mem_wmask;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_rdata(d_rdata), .d_valid(d_valid), .err(err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Simultaneous fetch and data request: data must be served first, then fetch.
  task automatic pair(input logic [31:0] ia, input logic [31:0] da, input logic [31:0] dw,
                      input logic [3:0] dm, input logic [31:0] rd_d, input logic [31:0] rd_i);
    logic [31:0] a;
    if_req = 1; if_addr = ia; d_req = 1; d_addr = da; d_wdata = dw; d_wmask = dm;
    tick();
    a = {da[31:2], 2'b00};
    check("pair_d_req",   mem_req,   1);
    check("pair_d_addr",  mem_addr,  a);
    check("pair_d_wmask", mem_wmask, dm);
    check("pair_d_wdata", mem_wdata, dw);
    mem_ack = 1; mem_rdata = rd_d;
    tick();
    check("pair_d_valid", d_valid,  1);
    check("pair_d_rdata", d_rdata,  rd_d);
    check("pair_i_idle",  if_valid, 0);
    d_req = 0; mem_ack = 0;
    tick();
    a = {ia[31:2], 2'b00};
    check("pair_i_req",   mem_req,   1);
    check("pair_i_addr",  mem_addr,  a);
    check("pair_i_wmask", mem_wmask, 0);
    check("pair_i_wdata", mem_wdata, 0);
    mem_ack = 1; mem_rdata = rd_i;
    tick();
    check("pair_i_valid", if_valid, 1);
    check("pair_i_rdata", if_rdata, rd_i);
    if_req = 0; mem_ack = 0;
    tick();
  endtask

  // Reference model state for the randomized phase.
  logic        m_req, m_iv, m_dv, m_err;
  logic [31:0] m_addr, m_wdata, m_ir, m_dr;
  logic [3:0]  m_wmask;
  logic        n_req, n_iv, n_dv, n_err;
  logic [31:0] n_addr, n_wdata, n_ir, n_dr, rd, wa;
  logic [3:0]  n_wmask;
  logic        last_d, el_i, el_d, win_d;
  int          owner;   // 0 none, 1 fetch, 2 data
  int          busy_n;  // how many cycles mem_req has been high so far
  int          ack_at;  // bus cycle index (from 0) at which memory acks
  int          n;

  initial begin
    reset = 1; if_req = 0; d_req = 0; mem_ack = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0; d_wmask = 0; mem_rdata = 0;
    tick(); tick();
    check("rst_mem_req",  mem_req,  0);
    check("rst_if_valid", if_valid, 0);
    check("rst_d_valid",  d_valid,  0);
    check("rst_err",      err,      0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_if_rdata", if_rdata, 0);
    reset = 0;

    // Zero-wait fetch: mem_req in cycle 1, valid in cycle 2.
    if_req = 1; if_addr = 32'h100;
    tick();
    check("f_mem_req",   mem_req,   1);
    check("f_mem_addr",  mem_addr,  32'h100);
    check("f_mem_wmask", mem_wmask, 0);
    mem_ack = 1; mem_rdata = 32'h13;
    tick();
    check("f_if_valid", if_valid, 1);
    check("f_if_rdata", if_rdata, 32'h13);
    check("f_err",      err,      0);
    check("f_mem_req0", mem_req,  0);
    if_req = 0; mem_ack = 0;
    tick();
    check("f_valid_pulse", if_valid, 0);
    check("f_rdata_hold",  if_rdata, 32'h13);

    // Round-robin: D first, then I, twice.
    pair(32'h104, 32'h2002, 32'hBEEF0000, 4'b1100, 32'hDEADBEEF, 32'h11111111);
    pair(32'h108, 32'h2004, 32'h0000CAFE, 4'b0011, 32'h22222222, 32'h33333333);

    // Data read with 5 wait cycles before the ack.
    d_req = 1; d_addr = 32'h3008; d_wmask = 0; d_wdata = 0;
    tick();
    for (int k = 0; k < 5; k++) begin
      check("w_mem_req",   mem_req,   1);
      check("w_mem_addr",  mem_addr,  32'h3008);
      check("w_mem_wmask", mem_wmask, 0);
      check("w_no_valid",  d_valid,   0);
      tick();
    end
    check("w_ack_req", mem_req, 1);
    mem_ack = 1; mem_rdata = 32'h5A5A5A5A;
    tick();
    check("w_d_valid", d_valid, 1);
    check("w_d_rdata", d_rdata, 32'h5A5A5A5A);
    check("w_err",     err,     0);
    mem_ack = 0; d_req = 0;
    tick();

    // Timeout: no ack ever, mem_req held exactly TIMEOUT cycles.
    d_req = 1; d_addr = 32'h4000; d_wmask = 0;
    tick();
    n = 0;
    for (int k = 0; k < 40 && mem_req; k++) begin
      n++;
      tick();
    end
    check("to_len",     n,       TIMEOUT);
    check("to_d_valid", d_valid, 1);
    check("to_err",     err,     1);
    check("to_d_rdata", d_rdata, 0);
    check("to_mem_req", mem_req, 0);
    d_req = 0;
    tick();
    check("to_err_pulse", err,     0);
    check("to_idle",      mem_req, 0);

    // Ack in the last wait cycle wins over the timeout.
    d_req = 1; d_addr = 32'h4004;
    tick();
    for (int k = 0; k < TIMEOUT - 1; k++) tick();
    check("co_req", mem_req, 1);
    mem_ack = 1; mem_rdata = 32'hCAFE0001;
    tick();
    check("co_d_valid", d_valid, 1);
    check("co_err",     err,     0);
    check("co_d_rdata", d_rdata, 32'hCAFE0001);
    mem_ack = 0; d_req = 0;
    tick();

    // Reset during BUSY_I, late ack ignored, next request normal.
    if_req = 1; if_addr = 32'h500;
    tick();
    check("ra_busy", mem_req, 1);
    reset = 1; if_req = 0;
    tick();
    check("ra_mem_req", mem_req,  0);
    check("ra_valid",   if_valid, 0);
    check("ra_rdata",   if_rdata, 0);
    reset = 0; mem_ack = 1; mem_rdata = 32'h77;
    tick();
    check("ra_late_valid", if_valid, 0);
    check("ra_late_req",   mem_req,  0);
    mem_ack = 0; if_req = 1; if_addr = 32'h600;
    tick();
    check("ra_new_req",  mem_req,  1);
    check("ra_new_addr", mem_addr, 32'h600);
    mem_ack = 1; mem_rdata = 32'h66;
    tick();
    check("ra_new_valid", if_valid, 1);
    check("ra_new_rdata", if_rdata, 32'h66);
    mem_ack = 0; if_req = 0;
    tick();

    // Requester keeps req high in its valid cycle.
    if_req = 1; if_addr = 32'h700;
    tick();
    mem_ack = 1; mem_rdata = 32'h70;
    tick();
    check("kr_valid", if_valid, 1);
    mem_ack = 0; if_addr = 32'h704;
    tick();
    check("kr_no_regrant", mem_req,  0);
    check("kr_pulse",      if_valid, 0);
    tick();
    check("kr_regrant", mem_req,  1);
    check("kr_addr",    mem_addr, 32'h704);
    mem_ack = 1; mem_rdata = 32'h74;
    tick();
    check("kr_valid2", if_valid, 1);
    check("kr_rdata2", if_rdata, 32'h74);
    mem_ack = 0; if_req = 0;

    // Randomized phase against the reference model.
    reset = 1;
    tick();
    reset = 0;
    m_req = 0; m_iv = 0; m_dv = 0; m_err = 0; m_ir = 0; m_dr = 0;
    m_addr = 0; m_wdata = 0; m_wmask = 0;
    last_d = 0; owner = 0; busy_n = 0; ack_at = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      // Requesters: retire on valid (maybe issuing a new request at once),
      // otherwise hold or occasionally raise a new request.
      if (m_iv) begin
        if_req = ($urandom_range(0, 1) == 1);
        if_addr = $urandom;
      end else if (!if_req && $urandom_range(0, 3) == 0) begin
        if_req = 1; if_addr = $urandom;
      end
      if (m_dv || (!d_req && $urandom_range(0, 3) == 0)) begin
        d_req = m_dv ? ($urandom_range(0, 1) == 1) : 1'b1;
        d_addr = $urandom; d_wdata = $urandom;
        d_wmask = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
      end
      // Memory: ack on the chosen bus cycle; stray acks while idle.
      mem_rdata = $urandom;
      if (m_req) mem_ack = (busy_n - 1 == ack_at);
      else       mem_ack = ($urandom_range(0, 7) == 0);

      // Expected values after the coming edge.
      n_req = m_req; n_addr = m_addr; n_wdata = m_wdata; n_wmask = m_wmask;
      n_iv = 0; n_dv = 0; n_err = 0; n_ir = m_ir; n_dr = m_dr;
      if (!m_req) begin
        el_i = if_req && !m_iv;
        el_d = d_req && !m_dv;
        if (el_i || el_d) begin
          win_d  = el_d && !(el_i && last_d);
          last_d = win_d;
          owner  = win_d ? 2 : 1;
          wa     = win_d ? d_addr : if_addr;
          n_req  = 1;
          n_addr = {wa[31:2], 2'b00};
          n_wdata = win_d ? d_wdata : 32'h0;
          n_wmask = win_d ? d_wmask : 4'h0;
          busy_n = 1;
          case ($urandom_range(0, 9))
            0:       ack_at = 1000;
            1:       ack_at = TIMEOUT - 1;
            default: ack_at = $urandom_range(0, 4);
          endcase
        end
      end else if (mem_ack || busy_n == TIMEOUT) begin
        n_req = 0;
        n_err = !mem_ack;
        rd = mem_ack ? mem_rdata : 32'h0;
        if (owner == 1) begin n_iv = 1; n_ir = rd; end
        else            begin n_dv = 1; n_dr = rd; end
        owner = 0; busy_n = 0;
      end else begin
        busy_n++;
      end

      tick();
      check("rnd_mem_req", mem_req, n_req);
      if (n_req) begin
        check("rnd_mem_addr",  mem_addr,  n_addr);
        check("rnd_mem_wdata", mem_wdata, n_wdata);
        check("rnd_mem_wmask", mem_wmask, n_wmask);
      end
      check("rnd_if_valid", if_valid, n_iv);
      check("rnd_d_valid",  d_valid,  n_dv);
      check("rnd_err",      err,      n_err);
      check("rnd_if_rdata", if_rdata, n_ir);
      check("rnd_d_rdata",  d_rdata,  n_dr);
      m_req = n_req; m_addr = n_addr; m_wdata = n_wdata; m_wmask = n_wmask;
      m_iv = n_iv; m_dv = n_dv; m_err = n_err; m_ir = n_ir; m_dr = n_dr;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
